weight_stabilizer: RTL and testbench

- Upstream conditioning stage for package_sorter.
- Takes raw 12-bit load-cell samples qualified by a valid strobe, rejects bounce and noise, and drives the sorter's `weight` input.
- Publishes a weight only after consecutive in-tolerance samples, and returns to zero only after consecutive empty samples.
- The sorter therefore sees exactly one zero→nonzero transition per physical package.

---
 rtl/weight_stabilizer.sv | 149 ++++++++++++++
 tb/tb_weight_stabilizer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/weight_stabilizer.sv
// Load-cell conditioning stage: debounces raw samples and publishes a stable
// nonzero weight once per package, returning to zero only after confirmed removal.
module weight_stabilizer #(
  parameter int STABLE_CNT = 4,
  parameter int TOL        = 8,
  parameter int ZERO_THR   = 4,
  parameter int HOLD_EMPTY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] raw_weight,
  input  logic        raw_valid,
  output logic [11:0] weight,
  output logic        stable,
  output logic        obj_start,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(STABLE_CNT) + 1;
  localparam int EW = $clog2(HOLD_EMPTY) + 1;

  typedef enum logic [1:0] {S_EMPTY, S_SETTLE, S_STABLE, S_LEAVING} state_t;

  state_t        state_q, state_d;
  logic [11:0]   weight_q, weight_d;
  logic [11:0]   ref_q, ref_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [EW-1:0] ecnt_q, ecnt_d, ecnt_inc;
  logic          stable_q, obj_start_q;
  logic          is_empty, in_ref, in_wt;
  logic          do_restart, do_leave;
  logic [12:0]   diff_ref, diff_wt;

  // Absolute differences are formed in 13 bits so the subtraction never wraps.
  always_comb begin
    diff_ref = (raw_weight >= ref_q)    ? ({1'b0, raw_weight} - {1'b0, ref_q})
                                        : ({1'b0, ref_q} - {1'b0, raw_weight});
    diff_wt  = (raw_weight >= weight_q) ? ({1'b0, raw_weight} - {1'b0, weight_q})
                                        : ({1'b0, weight_q} - {1'b0, raw_weight});
    is_empty = (raw_weight <= 12'(ZERO_THR));
    in_ref   = (diff_ref <= 13'(TOL));
    in_wt    = (diff_wt <= 13'(TOL));
    cnt_inc  = (cnt_q < CW'(STABLE_CNT)) ? cnt_q + 1'b1 : cnt_q;
    ecnt_inc = (ecnt_q < EW'(HOLD_EMPTY)) ? ecnt_q + 1'b1 : ecnt_q;
  end

  always_comb begin
    state_d    = state_q;
    weight_d   = weight_q;
    ref_d      = ref_q;
    cnt_d      = cnt_q;
    ecnt_d     = ecnt_q;
    do_restart = 1'b0;
    do_leave   = 1'b0;

    if (raw_valid) begin
      unique case (state_q)
        S_EMPTY: if (!is_empty) do_restart = 1'b1;
        S_SETTLE: begin
          if (is_empty) begin
            if (weight_q == 12'd0) begin
              state_d = S_EMPTY;
              cnt_d   = '0;
            end else begin
              do_leave = 1'b1;
            end
          end else if (in_ref) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CW'(STABLE_CNT)) begin
              weight_d = raw_weight;
              state_d  = S_STABLE;
            end
          end else begin
            do_restart = 1'b1;
          end
        end
        S_STABLE: begin
          if (is_empty)    do_leave   = 1'b1;
          else if (!in_wt) do_restart = 1'b1;
        end
        S_LEAVING: begin
          if (is_empty) begin
            ecnt_d = ecnt_inc;
            if (ecnt_inc >= EW'(HOLD_EMPTY)) begin
              weight_d = 12'd0;
              state_d  = S_EMPTY;
              ecnt_d   = '0;
            end
          end else if (in_wt) begin
            state_d = S_STABLE;
            ecnt_d  = '0;
          end else begin
            do_restart = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end

    // A fresh candidate value; with a one-sample window it is confirmed at once.
    if (do_restart) begin
      ref_d = raw_weight;
      cnt_d = CW'(1);
      if (STABLE_CNT == 1) begin
        weight_d = raw_weight;
        state_d  = S_STABLE;
      end else begin
        state_d = S_SETTLE;
      end
    end

    if (do_leave) begin
      if (HOLD_EMPTY == 1) begin
        weight_d = 12'd0;
        state_d  = S_EMPTY;
        ecnt_d   = '0;
      end else begin
        ecnt_d  = EW'(1);
        state_d = S_LEAVING;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      weight_q    <= 12'd0;
      ref_q       <= 12'd0;
      cnt_q       <= '0;
      ecnt_q      <= '0;
      stable_q    <= 1'b0;
      obj_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      weight_q    <= weight_d;
      ref_q       <= ref_d;
      cnt_q       <= cnt_d;
      ecnt_q      <= ecnt_d;
      stable_q    <= (state_d == S_STABLE);
      obj_start_q <= (weight_q == 12'd0) && (weight_d != 12'd0);
    end
  end

  assign weight    = weight_q;
  assign stable    = stable_q;
  assign obj_start = obj_start_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_weight_stabilizer.sv
// Directed bench for weight_stabilizer: hand-computed weight/stable/obj_start
// expectations for each sample, checked one time unit after the sampling edge.
module tb_weight_stabilizer;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] raw_weight;
  logic        raw_valid;
  logic [11:0] weight;
  logic        stable;
  logic        obj_start;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;

  weight_stabilizer dut (
    .clk        (clk),
    .reset      (reset),
    .raw_weight (raw_weight),
    .raw_valid  (raw_valid),
    .weight     (weight),
    .stable     (stable),
    .obj_start  (obj_start),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then check just after the rising edge.
  task automatic step(input logic rst, input logic v, input logic [11:0] w,
                      input logic [11:0] exp_w, input logic exp_s, input logic exp_o,
                      input string tag);
    @(negedge clk);
    reset      = rst;
    raw_valid  = v;
    raw_weight = w;
    @(posedge clk);
    #1;
    chk({tag, ".weight"}, weight, exp_w);
    chk({tag, ".stable"}, {11'd0, stable}, {11'd0, exp_s});
    chk({tag, ".obj_start"}, {11'd0, obj_start}, {11'd0, exp_o});
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp);
    chk(tag, {10'd0, dbg_state}, {10'd0, exp});
  endtask

  initial begin
    reset = 1'b1; raw_valid = 1'b0; raw_weight = 12'd0;

    step(1, 0, 0,    0, 0, 0, "rst0");
    step(1, 1, 900,  0, 0, 0, "rst1");
    chk_state("rst.state", ST_EMPTY);

    // basic publish
    step(0, 1, 270,  0, 0, 0, "t1.s1");
    step(0, 1, 272,  0, 0, 0, "t1.s2");
    step(0, 1, 268,  0, 0, 0, "t1.s3");
    step(0, 1, 271,  271, 1, 1, "t1.s4");
    step(0, 1, 0,    271, 0, 0, "t1.rm1");
    step(0, 1, 0,    0, 0, 0, "t1.rm2");

    // bounce restarts the window twice
    step(0, 1, 300,  0, 0, 0, "t2.s1");
    step(0, 1, 320,  0, 0, 0, "t2.s2");
    step(0, 1, 301,  0, 0, 0, "t2.s3");
    step(0, 1, 299,  0, 0, 0, "t2.s4");
    step(0, 1, 302,  0, 0, 0, "t2.s5");
    step(0, 1, 300,  300, 1, 1, "t2.s6");

    // noise dip, then removal
    step(0, 1, 2,    300, 0, 0, "t3.dip");
    step(0, 1, 300,  300, 1, 0, "t3.back");
    step(0, 1, 0,    300, 0, 0, "t3.rm1");
    step(0, 1, 0,    0, 0, 0, "t3.rm2");
    chk_state("t3.state", ST_EMPTY);

    // re-weigh without passing through zero
    step(0, 1, 501,  0, 0, 0, "t4.p1");
    step(0, 1, 501,  0, 0, 0, "t4.p2");
    step(0, 1, 501,  0, 0, 0, "t4.p3");
    step(0, 1, 501,  501, 1, 1, "t4.p4");
    step(0, 1, 1013, 501, 0, 0, "t4.r1");
    step(0, 1, 1013, 501, 0, 0, "t4.r2");
    step(0, 1, 1013, 501, 0, 0, "t4.r3");
    step(0, 1, 1013, 1013, 1, 0, "t4.r4");
    step(0, 1, 0,    1013, 0, 0, "t4.rm1");
    step(0, 1, 0,    0, 0, 0, "t4.rm2");

    // invalid cycles are ignored
    step(0, 1, 750,  0, 0, 0, "t5.s1");
    step(0, 1, 750,  0, 0, 0, "t5.s2");
    step(0, 0, 0,    0, 0, 0, "t5.g1");
    step(0, 0, 0,    0, 0, 0, "t5.g2");
    step(0, 0, 0,    0, 0, 0, "t5.g3");
    chk_state("t5.gap_state", ST_SETTLE);
    step(0, 1, 750,  0, 0, 0, "t5.s3");
    step(0, 1, 750,  750, 1, 1, "t5.s4");
    step(0, 1, 0,    750, 0, 0, "t5.rm1");
    step(0, 1, 0,    0, 0, 0, "t5.rm2");

    // reset mid-settle discards progress
    step(0, 1, 600,  0, 0, 0, "t6.s1");
    step(0, 1, 600,  0, 0, 0, "t6.s2");
    step(1, 1, 600,  0, 0, 0, "t6.rst");
    chk_state("t6.rst_state", ST_EMPTY);
    step(0, 1, 600,  0, 0, 0, "t6.a1");
    step(0, 1, 600,  0, 0, 0, "t6.a2");
    step(0, 1, 600,  0, 0, 0, "t6.a3");
    step(0, 1, 600,  600, 1, 1, "t6.a4");

    // tolerance boundary: diff 8 holds, diff 9 re-settles
    step(0, 1, 608,  600, 1, 0, "tol.in");
    step(0, 1, 609,  600, 0, 0, "tol.out");
    step(0, 1, 609,  600, 0, 0, "tol.s2");
    step(0, 1, 609,  600, 0, 0, "tol.s3");
    step(0, 1, 609,  609, 1, 0, "tol.s4");
    step(0, 1, 0,    609, 0, 0, "tol.rm1");
    step(0, 1, 0,    0, 0, 0, "tol.rm2");

    // zero threshold boundary: 4 is empty, 5 is not
    step(0, 1, 4,    0, 0, 0, "zt.4");
    chk_state("zt.4_state", ST_EMPTY);
    step(0, 1, 5,    0, 0, 0, "zt.5");
    chk_state("zt.5_state", ST_SETTLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
